// File: rtl/flash_bus_pkg.sv
// -----------------------------------------------------------------------------
// flash_bus_pkg
//   Shared definitions for the 6809-to-SPI-flash bus bridge:
//     - FLASH_ADDR_W   : width of the flash byte address (24)
//     - IDLE_READ_DATA : value returned to the CPU when no read data exists
//     - bridge_state_e : transaction FSM states
//     - flash_req_t    : one request towards the SPI engine
// -----------------------------------------------------------------------------
package flash_bus_pkg;

  localparam int         FLASH_ADDR_W   = 24;
  localparam logic [7:0] IDLE_READ_DATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } bridge_state_e;

  typedef struct packed {
    logic                    write;
    logic [FLASH_ADDR_W-1:0] addr;
    logic [7:0]              wdata;
  } flash_req_t;

endpackage

// File: rtl/bus_sync_edge.sv
// -----------------------------------------------------------------------------
// bus_sync_edge
//   Brings one asynchronous CPU strobe into the clk domain through a chain of
//   SYNC_STAGES flops (minimum 2) and derives single-cycle edge pulses from
//   the last stage and one extra delay flop.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset (clears the chain)
//     d      in   asynchronous input
//     level  out  synchronised level
//     rise   out  one-cycle pulse on a 0->1 transition of level
//     fall   out  one-cycle pulse on a 1->0 transition of level
// -----------------------------------------------------------------------------
module bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/flash_bus_bridge.sv
// -----------------------------------------------------------------------------
// flash_bus_bridge
//   Upstream front end of the SPI flash engine. Synchronises the 6809 bus
//   strobes, turns every selected bus cycle into one request/response
//   transaction and stretches the CPU cycle (MRDY low) while read data is
//   outstanding. Writes are posted through a one-entry buffer; the CPU only
//   stalls on a write while that buffer is still occupied.
//
//   Ports:
//     clk, reset            system clock, asynchronous active-low reset
//     spi_ce                decoded chip select of the flash window (async)
//     i_enable, i_Q         6809 E and Q strobes (async)
//     i_RW                  6809 R/W, 1 = read
//     i_ADDRESS_BUS         6809 address (low ADDR_BITS forwarded)
//     i_DataBus             6809 write data
//     o_MemoryReady         MRDY, 0 stretches the bus cycle
//     o_rd_data             read data towards the CPU data-bus driver
//     o_req_*               request to the SPI engine (valid/ready handshake)
//     i_req_ready           engine accepts the request this cycle
//     i_rsp_valid/i_rsp_data  one-cycle completion pulse and read byte
//     o_timeout             sticky: a request never completed in time
// -----------------------------------------------------------------------------
module flash_bus_bridge
  import flash_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_BITS      = 12,    // 1..15
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_ce,
  input  logic                    i_enable,
  input  logic                    i_Q,
  input  logic                    i_RW,
  input  logic [15:0]             i_ADDRESS_BUS,
  input  logic [7:0]              i_DataBus,
  output logic                    o_MemoryReady,
  output logic [7:0]              o_rd_data,
  output logic                    o_req_valid,
  output logic                    o_req_write,
  output logic [FLASH_ADDR_W-1:0] o_req_addr,
  output logic [7:0]              o_req_wdata,
  input  logic                    i_req_ready,
  input  logic                    i_rsp_valid,
  input  logic [7:0]              i_rsp_data,
  output logic                    o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Strobe synchronisers
  // ---------------------------------------------------------------------------
  logic e_level, e_rise, e_fall;
  logic q_level, q_rise, q_fall;
  logic ce_level, ce_rise, ce_fall;

  bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk   (clk),
    .reset (reset),
    .d     (i_enable),
    .level (e_level),
    .rise  (e_rise),
    .fall  (e_fall)
  );

  bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
    .clk   (clk),
    .reset (reset),
    .d     (i_Q),
    .level (q_level),
    .rise  (q_rise),
    .fall  (q_fall)
  );

  bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk   (clk),
    .reset (reset),
    .d     (spi_ce),
    .level (ce_level),
    .rise  (ce_rise),
    .fall  (ce_fall)
  );

  logic unused_inputs;
  assign unused_inputs = &{1'b0, i_ADDRESS_BUS[15:ADDR_BITS], e_level, e_rise,
                           q_level, q_fall, ce_rise, ce_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bridge_state_e          state_q, state_d;
  flash_req_t             req_q, req_d;
  logic                   req_valid_q, req_valid_d;
  logic                   mrdy_q, mrdy_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   timeout_q, timeout_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   wbuf_full_q, wbuf_full_d;
  logic [ADDR_BITS-1:0]   wbuf_addr_q, wbuf_addr_d;
  logic [7:0]             wbuf_data_q, wbuf_data_d;
  logic [ADDR_BITS-1:0]   addr_hold_q, addr_hold_d;
  logic                   wr_pending_q, wr_pending_d;   // write seen at Q, data due at E fall
  logic                   wr_stall_q, wr_stall_d;       // MRDY held low for a write
  logic                   rd_pending_q, rd_pending_d;   // read accepted from the CPU, not yet answered

  // Bus-cycle events; R/W and address are stable on the pins by the Q rise.
  logic                 sel_cycle, rd_start, wr_start, rd_want;
  logic [ADDR_BITS-1:0] rd_addr_now;
  logic                 tmo_hit, buf_clear;

  assign sel_cycle   = q_rise & ce_level;
  assign rd_start    = sel_cycle & i_RW;
  assign wr_start    = sel_cycle & ~i_RW;
  assign rd_want     = rd_pending_q | rd_start;
  assign rd_addr_now = rd_start ? i_ADDRESS_BUS[ADDR_BITS-1:0] : addr_hold_q;
  assign tmo_hit     = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  // The buffer empties on this edge: its write completed or was abandoned.
  assign buf_clear   = (state_q == ST_WR_WAIT) & (i_rsp_valid | tmo_hit);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets its hold value first, so no path through this
    // block leaves a signal unassigned and no latch can be inferred.
    state_d      = state_q;
    req_d        = req_q;
    req_valid_d  = req_valid_q;
    mrdy_d       = mrdy_q;
    rd_data_d    = rd_data_q;
    timeout_d    = timeout_q;
    tcnt_d       = tcnt_q;
    wbuf_full_d  = wbuf_full_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_data_d  = wbuf_data_q;
    addr_hold_d  = addr_hold_q;
    wr_pending_d = wr_pending_q;
    wr_stall_d   = wr_stall_q;
    rd_pending_d = rd_pending_q;

    unique case (state_q)
      ST_IDLE: begin
        // A full buffer always drains first so a read never overtakes a write.
        if (wbuf_full_q) begin
          state_d     = ST_WR_REQ;
          req_valid_d = 1'b1;
          req_d.write = 1'b1;
          req_d.addr  = FLASH_ADDR_W'(wbuf_addr_q);
          req_d.wdata = wbuf_data_q;
        end else if (rd_want) begin
          state_d     = ST_RD_REQ;
          req_valid_d = 1'b1;
          req_d.write = 1'b0;
          req_d.addr  = FLASH_ADDR_W'(rd_addr_now);
        end
      end

      ST_WR_REQ: begin
        if (i_req_ready) begin
          state_d     = ST_WR_WAIT;
          req_valid_d = 1'b0;
          tcnt_d      = '0;
        end
      end

      ST_WR_WAIT: begin
        if (i_rsp_valid) begin
          wbuf_full_d = 1'b0;
          if (rd_want) begin
            state_d     = ST_RD_REQ;
            req_valid_d = 1'b1;
            req_d.write = 1'b0;
            req_d.addr  = FLASH_ADDR_W'(rd_addr_now);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_hit) begin
          // Abandon the write and any read queued behind it.
          state_d      = ST_IDLE;
          timeout_d    = 1'b1;
          wbuf_full_d  = 1'b0;
          mrdy_d       = 1'b1;
          wr_stall_d   = 1'b0;
          rd_pending_d = 1'b0;
          if (rd_pending_q) rd_data_d = IDLE_READ_DATA;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      ST_RD_REQ: begin
        if (i_req_ready) begin
          state_d     = ST_RD_WAIT;
          req_valid_d = 1'b0;
          tcnt_d      = '0;
        end
      end

      ST_RD_WAIT: begin
        if (i_rsp_valid) begin
          state_d      = ST_IDLE;
          rd_data_d    = i_rsp_data;
          mrdy_d       = 1'b1;
          rd_pending_d = 1'b0;
        end else if (tmo_hit) begin
          state_d      = ST_IDLE;
          timeout_d    = 1'b1;
          rd_data_d    = IDLE_READ_DATA;
          mrdy_d       = 1'b1;
          rd_pending_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // CPU-side bus events, evaluated after the FSM so they take precedence.
    if (sel_cycle) addr_hold_d = i_ADDRESS_BUS[ADDR_BITS-1:0];

    if (rd_start) begin
      rd_pending_d = 1'b1;
      mrdy_d       = 1'b0;
    end

    if (wr_start) begin
      wr_pending_d = 1'b1;
      // A buffer emptying on this very edge counts as empty: no stall.
      if (wbuf_full_q && !buf_clear) begin
        wr_stall_d = 1'b1;
        mrdy_d     = 1'b0;
      end
    end

    if (buf_clear && wr_stall_q) begin
      wr_stall_d = 1'b0;
      mrdy_d     = 1'b1;
    end

    // Write data is valid at the E fall; the stalled case only gets here
    // once MRDY released E, i.e. after the buffer drained.
    if (e_fall && wr_pending_q) begin
      wr_pending_d = 1'b0;
      if (!wbuf_full_q || buf_clear) begin
        wbuf_full_d = 1'b1;
        wbuf_addr_d = addr_hold_q;
        wbuf_data_d = i_DataBus;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      mrdy_q       <= 1'b1;
      rd_data_q    <= IDLE_READ_DATA;
      timeout_q    <= 1'b0;
      tcnt_q       <= '0;
      wbuf_full_q  <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      addr_hold_q  <= '0;
      wr_pending_q <= 1'b0;
      wr_stall_q   <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      mrdy_q       <= mrdy_d;
      rd_data_q    <= rd_data_d;
      timeout_q    <= timeout_d;
      tcnt_q       <= tcnt_d;
      wbuf_full_q  <= wbuf_full_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      addr_hold_q  <= addr_hold_d;
      wr_pending_q <= wr_pending_d;
      wr_stall_q   <= wr_stall_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign o_MemoryReady = mrdy_q;
  assign o_rd_data     = rd_data_q;
  assign o_req_valid   = req_valid_q;
  assign o_req_write   = req_q.write;
  assign o_req_addr    = req_q.addr;
  assign o_req_wdata   = req_q.wdata;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_flash_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_flash_bus_bridge
//   Drives 6809-style bus cycles (pins change on clk falling edges, one
//   quarter = QTR clocks), models the SPI engine, and checks requests and read
//   data against a scoreboard filled when each bus cycle is driven.
// -----------------------------------------------------------------------------
module tb_flash_bus_bridge;

  localparam int SYNC_STAGES    = 2;
  localparam int ADDR_BITS      = 12;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int QTR            = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_ce, i_enable, i_Q, i_RW;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  i_DataBus;
  logic        o_MemoryReady;
  logic [7:0]  o_rd_data;
  logic        o_req_valid, o_req_write;
  logic [23:0] o_req_addr;
  logic [7:0]  o_req_wdata;
  logic        i_req_ready, i_rsp_valid;
  logic [7:0]  i_rsp_data;
  logic        o_timeout;

  always #5 clk = ~clk;

  flash_bus_bridge #(
    .SYNC_STAGES    (SYNC_STAGES),
    .ADDR_BITS      (ADDR_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_ce        (spi_ce),
    .i_enable      (i_enable),
    .i_Q           (i_Q),
    .i_RW          (i_RW),
    .i_ADDRESS_BUS (i_ADDRESS_BUS),
    .i_DataBus     (i_DataBus),
    .o_MemoryReady (o_MemoryReady),
    .o_rd_data     (o_rd_data),
    .o_req_valid   (o_req_valid),
    .o_req_write   (o_req_write),
    .o_req_addr    (o_req_addr),
    .o_req_wdata   (o_req_wdata),
    .i_req_ready   (i_req_ready),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_data    (i_rsp_data),
    .o_timeout     (o_timeout)
  );

  typedef struct packed {
    logic        write;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } exp_req_t;

  exp_req_t   exp_req[$];
  logic [7:0] exp_rd[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Engine model controls and counters
  int         eng_latency = 40;
  bit         eng_respond = 1'b1;
  logic [7:0] eng_rd_data = 8'h00;
  int         rsp_cnt     = 0;
  int         req_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // SPI engine model: accepts one request, checks it against the scoreboard,
  // answers after eng_latency cycles (or never, when eng_respond is 0).
  // ---------------------------------------------------------------------------
  exp_req_t eng_e;
  logic     eng_w;

  initial begin
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && o_req_valid === 1'b1) begin
        i_req_ready = 1'b1;
        req_cnt++;
        check("req_expected", (exp_req.size() > 0) ? 1 : 0, 1);
        if (exp_req.size() > 0) begin
          eng_e = exp_req.pop_front();
          check("req_write", o_req_write, eng_e.write);
          check("req_addr", o_req_addr, eng_e.addr);
          if (eng_e.write) check("req_wdata", o_req_wdata, eng_e.wdata);
        end
        eng_w = o_req_write;
        @(negedge clk);
        i_req_ready = 1'b0;
        check("req_valid_drop", o_req_valid, 0);
        if (eng_respond) begin
          repeat (eng_latency - 2) @(negedge clk);
          check("one_outstanding", o_req_valid, 0);
          i_rsp_valid = 1'b1;
          i_rsp_data  = eng_w ? 8'h00 : eng_rd_data;
          rsp_cnt++;
          @(negedge clk);
          i_rsp_valid = 1'b0;
          if (!eng_w) begin
            check("rd_mrdy_on_rsp", o_MemoryReady, 1);
            check("rd_exp_available", (exp_rd.size() > 0) ? 1 : 0, 1);
            if (exp_rd.size() > 0) check("rd_data", o_rd_data, exp_rd.pop_front());
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One CPU bus cycle. Expected requests / read data are queued here.
  // ---------------------------------------------------------------------------
  task automatic bus_cycle(input bit rw, input logic [15:0] addr, input logic [7:0] data,
                           input bit sel, input bit expect_stall, input bit chk_issue,
                           output int waited, output int rsp_at_release);
    exp_req_t e;
    int n;
    @(negedge clk);
    spi_ce = sel; i_RW = rw; i_ADDRESS_BUS = addr; i_DataBus = data;
    if (sel) begin
      e.write = !rw;
      e.addr  = {12'h000, addr[11:0]};
      e.wdata = data;
      exp_req.push_back(e);
      if (rw && eng_respond) exp_rd.push_back(eng_rd_data);
    end
    @(negedge clk);
    i_Q = 1'b1;
    repeat (SYNC_STAGES) @(negedge clk);
    if (expect_stall) check("mrdy_before_latency", o_MemoryReady, 1);
    @(negedge clk);
    check("mrdy_at_latency", o_MemoryReady, expect_stall ? 0 : 1);
    repeat (QTR - SYNC_STAGES - 1) @(negedge clk);
    i_enable = 1'b1;
    repeat (QTR) @(negedge clk);
    i_Q = 1'b0;
    repeat (QTR) @(negedge clk);
    waited = 0;
    while (o_MemoryReady !== 1'b1 && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    rsp_at_release = rsp_cnt;
    check("mrdy_release", o_MemoryReady, 1);
    i_enable = 1'b0;
    if (chk_issue) begin
      n = 0;
      while (o_req_valid !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("wr_issue_latency", (n <= SYNC_STAGES + 2) ? 1 : 0, 1);
    end
    repeat (QTR) @(negedge clk);
    spi_ce = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int w, rel, snap;

  initial begin
    reset = 1'b0;
    spi_ce = 1'b0; i_enable = 1'b0; i_Q = 1'b0; i_RW = 1'b1;
    i_ADDRESS_BUS = 16'h0000; i_DataBus = 8'h00;

    // Reset values
    #12;
    check("rst_mrdy", o_MemoryReady, 1);
    check("rst_rd_data", o_rd_data, 8'hFF);
    check("rst_req_valid", o_req_valid, 0);
    check("rst_req_write", o_req_write, 0);
    check("rst_req_addr", o_req_addr, 0);
    check("rst_req_wdata", o_req_wdata, 0);
    check("rst_timeout", o_timeout, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Read with empty buffer
    eng_latency = 40; eng_rd_data = 8'hA5;
    bus_cycle(1'b1, 16'hE123, 8'h00, 1'b1, 1'b1, 1'b0, w, rel);
    check("rd_data_hold", o_rd_data, 8'hA5);
    repeat (10) @(negedge clk);

    // Posted write
    bus_cycle(1'b0, 16'hE010, 8'h3C, 1'b1, 1'b0, 1'b1, w, rel);
    repeat (eng_latency + 10) @(negedge clk);

    // Back-to-back writes: second stalls until the first completes
    bus_cycle(1'b0, 16'hE020, 8'h11, 1'b1, 1'b0, 1'b1, w, rel);
    snap = rsp_cnt;
    bus_cycle(1'b0, 16'hE021, 8'h22, 1'b1, 1'b1, 1'b0, w, rel);
    check("b2b_release_after_rsp", rel, snap + 1);
    repeat (eng_latency + 10) @(negedge clk);

    // Read after write to the same address
    eng_rd_data = 8'h55;
    bus_cycle(1'b0, 16'hE000, 8'h55, 1'b1, 1'b0, 1'b1, w, rel);
    bus_cycle(1'b1, 16'hE000, 8'h00, 1'b1, 1'b1, 1'b0, w, rel);
    check("raw_rd_data", o_rd_data, 8'h55);
    repeat (10) @(negedge clk);

    // Unselected cycle
    snap = req_cnt;
    bus_cycle(1'b1, 16'h8123, 8'h00, 1'b0, 1'b0, 1'b0, w, rel);
    repeat (10) @(negedge clk);
    check("unsel_no_req", req_cnt, snap);

    // Timeout on a read, then a normal read
    eng_respond = 1'b0;
    bus_cycle(1'b1, 16'hE0F0, 8'h00, 1'b1, 1'b1, 1'b0, w, rel);
    check("tmo_flag", o_timeout, 1);
    check("tmo_rd_data", o_rd_data, 8'hFF);
    check("tmo_wait_window", (w >= TIMEOUT_CYCLES - 40 && w <= TIMEOUT_CYCLES) ? 1 : 0, 1);
    eng_respond = 1'b1; eng_rd_data = 8'h5A;
    bus_cycle(1'b1, 16'hE0F1, 8'h00, 1'b1, 1'b1, 1'b0, w, rel);
    check("post_tmo_rd_data", o_rd_data, 8'h5A);
    repeat (10) @(negedge clk);

    // Reset during RD_WAIT
    eng_respond = 1'b0;
    snap = req_cnt;
    @(negedge clk);
    spi_ce = 1'b1; i_RW = 1'b1; i_ADDRESS_BUS = 16'hE055;
    exp_req.push_back({1'b0, 24'h000055, 8'h00});
    @(negedge clk);
    i_Q = 1'b1;
    repeat (QTR) @(negedge clk);
    i_enable = 1'b1;
    repeat (4) @(negedge clk);
    check("rdwait_mrdy_low", o_MemoryReady, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_mrdy", o_MemoryReady, 1);
    check("midrst_rd_data", o_rd_data, 8'hFF);
    check("midrst_req_valid", o_req_valid, 0);
    check("midrst_timeout", o_timeout, 0);
    i_Q = 1'b0; i_enable = 1'b0; spi_ce = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_no_req", o_req_valid, 0);
    check("postrst_req_cnt", req_cnt, snap + 1);

    check("req_queue_empty", exp_req.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
